// File: rtl/grf_wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline (p0) and long-latency (p1) writebacks with a
// busy-register scoreboard and p1 starvation guard. Define GRF_WB_ARBITER_TRACE_EN to print each write.
module grf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [4:0]  p0_addr,
    input  logic [31:0] p0_data,
    input  logic [31:0] p0_pc,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [4:0]  p1_addr,
    input  logic [31:0] p1_data,
    input  logic [31:0] p1_pc,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  chk_a1,
    input  logic [4:0]  chk_a2,
    output logic        stall,
    output logic        w_en,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [31:0] w_pc,
    output logic [31:0] busy_vec
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]  r_starve_cnt;
    logic [31:0] r_busy;
    logic        r_wen;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_wpc;

    logic [2:0]  w_cnt_eff;
    logic [2:0]  w_starve_next;
    logic [31:0] w_busy_next;
    logic        w_force;
    logic        w_p0_xfer;
    logic        w_p1_xfer;
    logic        w_any_xfer;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic [31:0] w_sel_pc;

    // While reset is held the arbiter behaves as if no starvation has accrued.
    assign w_cnt_eff  = reset ? 3'd0 : r_starve_cnt;
    assign w_force    = p1_valid && (w_cnt_eff >= LIMIT);
    assign p0_ready   = !w_force;
    assign p1_ready   = p1_valid && (!p0_valid || w_force);
    assign w_p0_xfer  = p0_valid && p0_ready;
    assign w_p1_xfer  = p1_ready;
    assign w_any_xfer = w_p0_xfer || w_p1_xfer;

    assign w_sel_addr = w_p1_xfer ? p1_addr : p0_addr;
    assign w_sel_data = w_p1_xfer ? p1_data : p0_data;
    assign w_sel_pc   = w_p1_xfer ? p1_pc   : p0_pc;

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!p1_valid || w_p1_xfer) begin
            w_starve_next = 3'd0;
        end else if (r_starve_cnt != 3'd7) begin
            w_starve_next = r_starve_cnt + 3'd1;
        end
    end

    // Issue set takes priority over writeback clear on the same register.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign w_busy_next[gi] = (iss_valid && (iss_addr == 5'(gi))) ||
                                         (r_busy[gi] && !(w_p1_xfer && (p1_addr == 5'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
            r_busy       <= 32'd0;
            r_wen        <= 1'b0;
            r_waddr      <= 5'd0;
            r_wdata      <= 32'd0;
            r_wpc        <= 32'd0;
        end else begin
            r_starve_cnt <= w_starve_next;
            r_busy       <= w_busy_next;
            r_wen        <= w_any_xfer && (w_sel_addr != 5'd0);
            if (w_any_xfer) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
                r_wpc   <= w_sel_pc;
            end
        end
    end

`ifdef GRF_WB_ARBITER_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_any_xfer && (w_sel_addr != 5'd0)) begin
            $display("%0t@%h: $%0d <= %h", $time, w_sel_pc, w_sel_addr, w_sel_data);
        end
    end
`else
    // Trace output is compiled out in this build.
`endif

    assign stall    = ((chk_a1 != 5'd0) && r_busy[chk_a1]) || ((chk_a2 != 5'd0) && r_busy[chk_a2]);
    assign w_en     = r_wen;
    assign w_addr   = r_waddr;
    assign w_data   = r_wdata;
    assign w_pc     = r_wpc;
    assign busy_vec = r_busy;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed table-driven bench for grf_wb_arbiter (default STARVE_LIMIT = 3).
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p1_valid, p1_ready;
    logic [4:0]  p0_addr, p1_addr, iss_addr, chk_a1, chk_a2, w_addr;
    logic [31:0] p0_data, p0_pc, p1_data, p1_pc, w_data, w_pc, busy_vec;
    logic        iss_valid, stall, w_en;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data), .p0_pc(p0_pc),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data), .p1_pc(p1_pc),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .chk_a1(chk_a1), .chk_a2(chk_a2),
        .stall(stall), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc), .busy_vec(busy_vec)
    );

    typedef struct {
        logic        rst;
        logic        p0v;
        logic [4:0]  p0a;
        logic [31:0] p0d, p0pc;
        logic        p1v;
        logic [4:0]  p1a;
        logic [31:0] p1d, p1pc;
        logic        issv;
        logic [4:0]  issa;
        logic [4:0]  a1, a2;
        logic        e_p0r, e_p1r, e_stall, e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata, e_wpc, e_busy;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        p0_valid = v.p0v; p0_addr = v.p0a; p0_data = v.p0d; p0_pc = v.p0pc;
        p1_valid = v.p1v; p1_addr = v.p1a; p1_data = v.p1d; p1_pc = v.p1pc;
        iss_valid = v.issv; iss_addr = v.issa; chk_a1 = v.a1; chk_a2 = v.a2;
    endtask

    initial begin
        // rst, p0{v,a,d,pc}, p1{v,a,d,pc}, iss{v,a}, chk{a1,a2}, exp{p0r,p1r,stall}, exp{wen,waddr,wdata,wpc,busy}
        vecs[0]  = '{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1,0,0, 0,0,0,0,0};
        vecs[1]  = '{0, 1,5,32'h1234,32'h3000, 0,0,0,0, 0,0, 0,0, 1,0,0, 1,5,32'h1234,32'h3000,0};
        vecs[2]  = '{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1,0,0, 0,5,32'h1234,32'h3000,0};
        vecs[3]  = '{0, 1,0,32'hFFFFFFFF,32'h3004, 0,0,0,0, 1,0, 0,0, 1,0,0, 0,0,32'hFFFFFFFF,32'h3004,0};
        vecs[4]  = '{0, 0,7,32'hDEAD,32'h3FFC, 0,6,32'hBEEF,32'h4FFC, 1,8, 8,0, 1,0,0, 0,0,32'hFFFFFFFF,32'h3004,32'h100};
        vecs[5]  = '{0, 0,0,0,0, 0,0,0,0, 0,0, 8,0, 1,0,1, 0,0,32'hFFFFFFFF,32'h3004,32'h100};
        vecs[6]  = '{0, 1,8,32'h55,32'h3008, 0,0,0,0, 0,0, 8,0, 1,0,1, 1,8,32'h55,32'h3008,32'h100};
        vecs[7]  = '{0, 0,0,0,0, 1,8,32'h88,32'h4000, 0,0, 8,0, 1,1,1, 1,8,32'h88,32'h4000,0};
        vecs[8]  = '{0, 0,0,0,0, 0,0,0,0, 0,0, 8,0, 1,0,0, 0,8,32'h88,32'h4000,0};
        vecs[9]  = '{0, 0,0,0,0, 0,0,0,0, 1,9, 0,0, 1,0,0, 0,8,32'h88,32'h4000,32'h200};
        vecs[10] = '{0, 0,0,0,0, 1,9,32'h99,32'h4004, 1,9, 0,9, 1,1,1, 1,9,32'h99,32'h4004,32'h200};
        vecs[11] = '{0, 0,0,0,0, 0,0,0,0, 0,0, 0,9, 1,0,1, 0,9,32'h99,32'h4004,32'h200};
        vecs[12] = '{0, 1,1,32'h101,32'h3101, 1,2,32'h200,32'h5000, 0,0, 0,0, 1,0,0, 1,1,32'h101,32'h3101,32'h200};
        vecs[13] = '{0, 1,1,32'h102,32'h3102, 1,2,32'h200,32'h5000, 0,0, 0,0, 1,0,0, 1,1,32'h102,32'h3102,32'h200};
        vecs[14] = '{0, 1,1,32'h103,32'h3103, 1,2,32'h200,32'h5000, 0,0, 0,0, 1,0,0, 1,1,32'h103,32'h3103,32'h200};
        vecs[15] = '{0, 1,1,32'h104,32'h3104, 1,2,32'h200,32'h5000, 0,0, 0,0, 0,1,0, 1,2,32'h200,32'h5000,32'h200};
        vecs[16] = '{0, 1,1,32'h105,32'h3105, 1,2,32'h200,32'h5000, 0,0, 0,0, 1,0,0, 1,1,32'h105,32'h3105,32'h200};
        vecs[17] = '{0, 1,1,32'h106,32'h3106, 1,2,32'h200,32'h5000, 0,0, 0,0, 1,0,0, 1,1,32'h106,32'h3106,32'h200};
        vecs[18] = '{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1,0,0, 0,1,32'h106,32'h3106,32'h200};
        vecs[19] = '{0, 1,1,32'h107,32'h3107, 1,10,32'hA0,32'h50A0, 1,3, 0,0, 1,0,0, 1,1,32'h107,32'h3107,32'h208};
        vecs[20] = '{0, 1,1,32'h108,32'h3108, 1,10,32'hA0,32'h50A0, 1,4, 3,0, 1,0,1, 1,1,32'h108,32'h3108,32'h218};
        vecs[21] = '{0, 1,1,32'h109,32'h3109, 1,10,32'hA0,32'h50A0, 0,0, 3,0, 1,0,1, 1,1,32'h109,32'h3109,32'h218};
        vecs[22] = '{1, 1,1,32'h10A,32'h310A, 1,10,32'hA0,32'h50A0, 1,5, 3,0, 1,0,1, 0,0,0,0,0};
        vecs[23] = '{0, 1,1,32'h10B,32'h310B, 1,10,32'hA0,32'h50A0, 0,0, 3,4, 1,0,0, 1,1,32'h10B,32'h310B,0};
        vecs[24] = '{0, 1,1,32'h10C,32'h310C, 1,10,32'hA0,32'h50A0, 0,0, 3,4, 1,0,0, 1,1,32'h10C,32'h310C,0};
        vecs[25] = '{0, 1,1,32'h10D,32'h310D, 1,10,32'hA0,32'h50A0, 0,0, 3,4, 1,0,0, 1,1,32'h10D,32'h310D,0};
        vecs[26] = '{0, 1,1,32'h10E,32'h310E, 1,10,32'hA0,32'h50A0, 0,0, 3,4, 0,1,0, 1,10,32'hA0,32'h50A0,0};

        // Reset with live traffic: the transfer offered during reset must be discarded.
        drive('{1, 1,5,32'hCAFE,32'h1111, 1,6,32'hF00D,32'h2222, 1,7, 7,6, 0,0,0, 0,0,0,0,0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0; iss_valid = 1'b0;
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_w_pc", w_pc, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_p0_ready", i), 32'(p0_ready), 32'(vecs[i].e_p0r));
            chk($sformatf("v%0d_p1_ready", i), 32'(p1_ready), 32'(vecs[i].e_p1r));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_w_en", i), 32'(w_en), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_w_addr", i), 32'(w_addr), 32'(vecs[i].e_waddr));
            chk($sformatf("v%0d_w_data", i), w_data, vecs[i].e_wdata);
            chk($sformatf("v%0d_w_pc", i), w_pc, vecs[i].e_wpc);
            chk($sformatf("v%0d_busy", i), busy_vec, vecs[i].e_busy);
            $display("vec %0d: w_en=%0b w_addr=%0d w_data=%h busy=%h", i, w_en, w_addr, w_data, busy_vec);
        end

        // Dropping p1_valid clears the starvation count: contention must restart from zero.
        begin
            logic [6:0] seq_p1v;
            logic [6:0] seq_p1r;
            seq_p1v = 7'b1111011;   // bit i = p1_valid in step i
            seq_p1r = 7'b1000000;   // bit i = expected p1_ready in step i
            for (int i = 0; i < 7; i++) begin
                reset = 1'b0; iss_valid = 1'b0; chk_a1 = 5'd0; chk_a2 = 5'd0;
                p0_valid = 1'b1; p0_addr = 5'd12; p0_data = 32'(i); p0_pc = 32'h6000;
                p1_valid = seq_p1v[i]; p1_addr = 5'd13; p1_data = 32'h77; p1_pc = 32'h7000;
                @(negedge clk);
                chk($sformatf("clr%0d_p1_ready", i), 32'(p1_ready), 32'(seq_p1r[i]));
                chk($sformatf("clr%0d_p0_ready", i), 32'(p0_ready), 32'(!seq_p1r[i]));
                @(posedge clk);
                #1;
                chk($sformatf("clr%0d_w_addr", i), 32'(w_addr), seq_p1r[i] ? 32'd13 : 32'd12);
                $display("clr %0d: p1_valid=%0b w_addr=%0d", i, seq_p1v[i], w_addr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
